pipe_hold_ctrl: RTL and testbench



---
 rtl/pipe_hold_ctrl_if.sv | 30 +++
 rtl/pipe_hold_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hold_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | pipe_hold_ctrl_if : hazard request / HoldFlag bundle for pipe_hold_ctrl     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pipe_hold_ctrl_if;
    logic       trap_req;
    logic       bus_busy;
    logic       jump_req;
    logic       load_use;
    logic [2:0] hold_if_id;
    logic [2:0] hold_id_ex;
    logic [2:0] hold_ex_mem;
    logic       timeout_err;
    logic       busy;

    // master raises hazard requests; slave is the controller producing HoldFlags
    modport master (
        output trap_req, bus_busy, jump_req, load_use,
        input  hold_if_id, hold_id_ex, hold_ex_mem, timeout_err, busy
    );

    modport slave (
        input  trap_req, bus_busy, jump_req, load_use,
        output hold_if_id, hold_id_ex, hold_ex_mem, timeout_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipe_hold_ctrl : merges trap/bus/jump/load-use into per-boundary HoldFlags |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_hold_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int TRAP_CYCLES = 2,
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_hold_ctrl_if.slave    hz_if
);

    localparam logic [2:0] HF_RUN   = 3'b000;
    localparam logic [2:0] HF_FLUSH = 3'b001;
    localparam logic [2:0] HF_LDUSE = 3'b010;
    localparam logic [2:0] HF_TRAP  = 3'b011;
    localparam logic [2:0] HF_BUS   = 3'b100;

    localparam logic [CNT_W-1:0] TCNT_REQ  = CNT_W'(TRAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TCNT_FULL = CNT_W'(TRAP_CYCLES);
    localparam logic [CNT_W-1:0] WCNT_TOP  = CNT_W'(BUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] JCNT_LOAD = CNT_W'(FLUSH_EXTRA);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_JUMP_FLUSH = 2'd1,
        ST_TRAP_FLUSH = 2'd2,
        ST_BUS_WAIT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] jcnt_q, jcnt_d;
    logic             terr_q, terr_d;
    logic [2:0]       if_id_code, id_ex_code, ex_mem_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
            jcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            wcnt_q  <= wcnt_d;
            jcnt_q  <= jcnt_d;
            terr_q  <= terr_d;
        end
    end

    // A non-zero jcnt outside TRAP_FLUSH means a jump flush is still owed,
    // which is how the flush survives a bus wait with its count frozen.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        wcnt_d      = wcnt_q;
        jcnt_d      = jcnt_q;
        terr_d      = 1'b0;
        if_id_code  = HF_RUN;
        id_ex_code  = HF_RUN;
        ex_mem_code = HF_RUN;

        if (state_q == ST_TRAP_FLUSH) begin
            if_id_code  = HF_TRAP;
            id_ex_code  = HF_TRAP;
            ex_mem_code = HF_TRAP;
            wcnt_d      = '0;
            jcnt_d      = '0;
            if (tcnt_q <= CNT_W'(1)) begin
                tcnt_d  = '0;
                state_d = ST_RUN;
            end else begin
                tcnt_d  = tcnt_q - CNT_W'(1);
            end
        end else if (hz_if.trap_req) begin
            if_id_code  = HF_TRAP;
            id_ex_code  = HF_TRAP;
            ex_mem_code = HF_TRAP;
            wcnt_d      = '0;
            jcnt_d      = '0;
            if (TRAP_CYCLES > 1) begin
                tcnt_d  = TCNT_REQ;
                state_d = ST_TRAP_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end else if (hz_if.bus_busy) begin
            if_id_code  = HF_BUS;
            id_ex_code  = HF_BUS;
            ex_mem_code = HF_BUS;
            if (wcnt_q == WCNT_TOP) begin
                terr_d  = 1'b1;
                wcnt_d  = '0;
                jcnt_d  = '0;
                tcnt_d  = TCNT_FULL;
                state_d = ST_TRAP_FLUSH;
            end else begin
                wcnt_d  = wcnt_q + CNT_W'(1);
                state_d = ST_BUS_WAIT;
            end
        end else begin
            wcnt_d  = '0;
            state_d = ST_RUN;
            if (hz_if.jump_req) begin
                if_id_code = HF_FLUSH;
                id_ex_code = HF_FLUSH;
                jcnt_d     = JCNT_LOAD;
                if (FLUSH_EXTRA > 0) begin
                    state_d = ST_JUMP_FLUSH;
                end
            end else if (jcnt_q != '0) begin
                if_id_code = HF_FLUSH;
                jcnt_d     = jcnt_q - CNT_W'(1);
                if (jcnt_q != CNT_W'(1)) begin
                    state_d = ST_JUMP_FLUSH;
                end
            end else if (hz_if.load_use) begin
                if_id_code = HF_LDUSE;
                id_ex_code = HF_FLUSH;
            end
        end
    end

    // Pipeline registers see a flush on every boundary while reset is held.
    assign hz_if.hold_if_id  = rst ? if_id_code  : HF_FLUSH;
    assign hz_if.hold_id_ex  = rst ? id_ex_code  : HF_FLUSH;
    assign hz_if.hold_ex_mem = rst ? ex_mem_code : HF_FLUSH;
    assign hz_if.timeout_err = terr_q;
    assign hz_if.busy        = (state_q != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pipe_hold_ctrl : scoreboard bench for pipe_hold_ctrl                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hold_ctrl;

    localparam logic [2:0] RN = 3'b000;
    localparam logic [2:0] FL = 3'b001;
    localparam logic [2:0] LU = 3'b010;
    localparam logic [2:0] TR = 3'b011;
    localparam logic [2:0] BS = 3'b100;

    typedef struct {
        int         id;
        bit         sel;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
        logic       terr;
        logic       bsy;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   cyc_id;
    exp_t sb[$];
    exp_t e;
    logic [2:0] oa, ob, oc;
    logic       oterr, obsy;

    pipe_hold_ctrl_if if1();
    pipe_hold_ctrl_if if3();

    pipe_hold_ctrl u_dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (if1)
    );

    pipe_hold_ctrl #(.FLUSH_EXTRA(3)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .hz_if (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of requests and queue what both boundaries must show
    task automatic cyc(input logic t, input logic b, input logic j, input logic l,
                       input bit sel, input logic [2:0] ea, input logic [2:0] eb,
                       input logic [2:0] ec, input logic et, input logic ebsy);
        if1.trap_req = t; if1.bus_busy = b; if1.jump_req = j; if1.load_use = l;
        if3.trap_req = t; if3.bus_busy = b; if3.jump_req = j; if3.load_use = l;
        sb.push_back('{cyc_id, sel, ea, eb, ec, et, ebsy});
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit sel);
        rst = 1'b0;
        repeat (3) cyc(0, 0, 0, 0, sel, FL, FL, FL, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                oa = if3.hold_if_id; ob = if3.hold_id_ex; oc = if3.hold_ex_mem;
                oterr = if3.timeout_err; obsy = if3.busy;
            end else begin
                oa = if1.hold_if_id; ob = if1.hold_id_ex; oc = if1.hold_ex_mem;
                oterr = if1.timeout_err; obsy = if1.busy;
            end
            check_val($sformatf("c%0d_if_id", e.id),  32'(oa),    32'(e.a));
            check_val($sformatf("c%0d_id_ex", e.id),  32'(ob),    32'(e.b));
            check_val($sformatf("c%0d_ex_mem", e.id), 32'(oc),    32'(e.c));
            check_val($sformatf("c%0d_terr", e.id),   32'(oterr), 32'(e.terr));
            check_val($sformatf("c%0d_busy", e.id),   32'(obsy),  32'(e.bsy));
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc_id  = 0;
        rst     = 1'b0;
        if1.trap_req = 0; if1.bus_busy = 0; if1.jump_req = 0; if1.load_use = 0;
        if3.trap_req = 0; if3.bus_busy = 0; if3.jump_req = 0; if3.load_use = 0;
        @(posedge clk);
        #1;

        do_reset(0);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // jump with one extra IF/ID flush cycle
        cyc(0, 0, 1, 0, 0, FL, FL, RN, 0, 0);
        cyc(0, 0, 0, 0, 0, FL, RN, RN, 0, 1);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // load-use for two cycles
        cyc(0, 0, 0, 1, 0, LU, FL, RN, 0, 0);
        cyc(0, 0, 0, 1, 0, LU, FL, RN, 0, 0);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // jump beats load-use; load-use ignored during the jump flush
        cyc(0, 0, 1, 1, 0, FL, FL, RN, 0, 0);
        cyc(0, 0, 0, 1, 0, FL, RN, RN, 0, 1);
        cyc(0, 0, 0, 1, 0, LU, FL, RN, 0, 0);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // trap during jump flush; jump inside trap flush ignored
        cyc(0, 0, 1, 0, 0, FL, FL, RN, 0, 0);
        cyc(1, 0, 0, 0, 0, TR, TR, TR, 0, 1);
        cyc(0, 0, 1, 0, 0, TR, TR, TR, 0, 1);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // short bus wait
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, BS, BS, BS, 0, (i != 0));
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 1);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // bus held 20 cycles: timeout after 16, trap flush, then waiting again
        for (int i = 0; i < 20; i++) begin
            if (i < 16)       cyc(0, 1, 0, 0, 0, BS, BS, BS, 0, (i != 0));
            else if (i == 16) cyc(0, 1, 0, 0, 0, TR, TR, TR, 1, 1);
            else if (i == 17) cyc(0, 1, 0, 0, 0, TR, TR, TR, 0, 1);
            else              cyc(0, 1, 0, 0, 0, BS, BS, BS, 0, (i == 19));
        end
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 1);
        cyc(0, 0, 0, 0, 0, RN, RN, RN, 0, 0);

        // FLUSH_EXTRA=3 instance: bus wait preempts the jump flush
        do_reset(1);
        cyc(0, 0, 0, 0, 1, RN, RN, RN, 0, 0);
        cyc(0, 0, 1, 0, 1, FL, FL, RN, 0, 0);
        cyc(0, 0, 0, 0, 1, FL, RN, RN, 0, 1);
        cyc(0, 1, 0, 0, 1, BS, BS, BS, 0, 1);
        cyc(0, 1, 0, 0, 1, BS, BS, BS, 0, 1);
        cyc(0, 0, 0, 0, 1, FL, RN, RN, 0, 1);
        cyc(0, 0, 0, 0, 1, FL, RN, RN, 0, 1);
        cyc(0, 0, 0, 0, 1, RN, RN, RN, 0, 0);

        @(negedge clk);
        #1;
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
